// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants, FSM encoding and width helpers for the seven-segment scan controller.
// Every segment/anode constant here is active-low, matching the common-anode board wiring.
package seg_scan_ctrl_pkg;

  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [3:0] AN_OFF     = 4'hF;
  localparam int         NUM_DIGITS = 4;

  typedef enum logic {
    DEAD = 1'b0,
    SHOW = 1'b1
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // A one-value counter still needs one bit of storage to stay legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex7.sv
// The team's 4-bit hex-to-seven-segment decoder; active-low outputs, seg[6] is G, seg[0] is A.
module seg_scan_ctrl_hex7 (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: default first so every path assigns seg and no latch is inferred.
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin 4-digit seven-segment scanner with dead-time gaps, blanking, blinking,
// leading-zero suppression and decimal points; one shared decoder, all outputs registered.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYC    = 500,
  parameter int BLINK_DIV   = 12500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_mask,
  input  logic [3:0]  blink_en,
  input  logic        lzb_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        slot_tick
);

  localparam int CNT_W = cnt_width(max_int(REFRESH_DIV, DEAD_CYC));
  localparam int BLK_W = cnt_width(BLINK_DIV);

  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST    = CNT_W'(DEAD_CYC - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST   = BLK_W'(BLINK_DIV - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;

  logic             slot_start, slot_end;
  logic [3:0]       cur_nib;
  logic [3:0]       upper_zero;
  logic             cur_dark;

  logic [3:0]       snap_nib;
  logic             snap_dp;
  logic             snap_dark;
  logic [6:0]       dec_seg;

  // ---------------------------------------------------------------------------
  // Slot FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= DEAD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    slot_start = 1'b0;
    slot_end   = 1'b0;
    case (state)
      DEAD: if (cnt == DEAD_LAST) begin
        state_next = SHOW;
        slot_start = 1'b1;
      end
      SHOW: if (cnt == REFRESH_LAST) begin
        state_next = DEAD;
        slot_end   = 1'b1;
      end
      default: state_next = DEAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Blank decision for the digit about to be shown (uses the pre-toggle blink phase)
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_nib       = digits[{idx, 2'b00} +: 4];
    upper_zero[0] = 1'b0;
    upper_zero[1] = (digits[15:4]  == 12'h000);
    upper_zero[2] = (digits[15:8]  == 8'h00);
    upper_zero[3] = (digits[15:12] == 4'h0);
    cur_dark      = blank_mask[idx]
                  | (blink_en[idx] & blink_phase)
                  | (lzb_en & upper_zero[idx]);
  end

  // ---------------------------------------------------------------------------
  // Slot counter, digit index and per-slot snapshot
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= 2'd0;
      snap_nib  <= 4'h0;
      snap_dp   <= 1'b0;
      snap_dark <= 1'b1;
    end else begin
      if (slot_start || slot_end) cnt <= '0;
      else                        cnt <= cnt + 1'b1;

      if (slot_end) idx <= idx + 2'd1;

      // Freezing the inputs for the whole slot keeps mid-slot updates from tearing.
      if (slot_start) begin
        snap_nib  <= cur_nib;
        snap_dp   <= dp_in[idx];
        snap_dark <= cur_dark;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Free-running blink timebase, independent of the scan
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  seg_scan_ctrl_hex7 u_hex7 (
    .nib (snap_nib),
    .seg (dec_seg)
  );

  // ---------------------------------------------------------------------------
  // Registered pin drive; lags the FSM state by one cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      an        <= AN_OFF;
      seg       <= SEG_OFF;
      dp        <= 1'b1;
      slot_tick <= 1'b0;
    end else begin
      slot_tick <= slot_start;
      if (state == SHOW && !snap_dark) begin
        an  <= ~(4'b0001 << idx);
        seg <= dec_seg;
        dp  <= ~snap_dp;
      end else begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexes one shared hex-to-seven-segment decoder across the 4 digits of the kitchen-timer display.
- Scans the digits round-robin, with a dead-time gap between digits to stop ghosting.
- Supports per-digit blanking, blinking, leading-zero suppression and decimal points.
- Sits between the timer/count logic (which supplies BCD nibbles) and the board's common-anode display pins.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit is lit per slot (1 kHz per digit at 50 MHz).
- DEAD_CYC, 500, clock cycles with all anodes off between slots; must be >= 1.
- BLINK_DIV, 12500000, clock cycles per blink half-period (2 Hz blink at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- digits  in  16  digit nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- dp_in  in  4  decimal point request per digit, 1 = lit.
- blank_mask  in  4  1 = force that digit dark.
- blink_en  in  4  1 = that digit blinks.
- lzb_en  in  1  1 = suppress leading zeros on digits 3..1.
- seg  out  7  segment drive, active-low; MSB is G, LSB is A.
- dp  out  1  decimal point drive, active-low.
- an  out  4  anode enables, active-low; an[i] selects digit i.
- slot_tick  out  1  one-cycle pulse when a new digit slot begins.

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous, active-high. All outputs are registered.
- Reset values: an=4'b1111, seg=7'h7F, dp=1, slot_tick=0. Internally: idx=0, state=DEAD, cnt=0, blink_cnt=0, blink_phase=0.
- FSM states: DEAD and SHOW.
- DEAD:
  - an=1111, seg=7'h7F, dp=1.
  - Lasts DEAD_CYC cycles, then goes to SHOW.
  - On the DEAD->SHOW edge: snapshot digits[4*idx+:4], dp_in[idx] and the blank decision for idx; assert slot_tick for 1 cycle.
- SHOW:
  - Drives the snapshot. Input changes mid-slot are ignored, so there is no tearing.
  - Lasts REFRESH_DIV cycles, then idx <= idx+1 (3 wraps to 0) and goes to DEAD.
- Output timing: outputs lag state by one cycle. an[idx] goes low the cycle after SHOW is entered and high the cycle after DEAD is entered.
- Scan period: 4*(DEAD_CYC+REFRESH_DIV) cycles. No two anodes are ever low together.
- Decode: the lit digit's nibble goes through the shared decoder; values A..F use the decoder's hex glyphs unchanged.
- Blank decision for digit i. The digit is dark if any of:
  - blank_mask[i]
  - blink_en[i] && blink_phase
  - lzb_en && i>0 && digits[3..i] are all 0 (digit 0 is never suppressed by lzb)
- Dark digit: an stays 1111 for the whole slot, seg=7'h7F, dp=1. Slot timing is unchanged.
- Lit digit: dp = ~dp_in[i].
- Blink counter: free-runs 0..BLINK_DIV-1 and toggles blink_phase on wrap, independent of the scan. blink_phase=0 means visible.
- Counter widths: cnt is $clog2(max(REFRESH_DIV,DEAD_CYC)); blink_cnt is $clog2(BLINK_DIV). Both compare against DIV-1; no overflow beyond wrap.
- Reset mid-slot: next cycle all outputs return to their reset values and scanning restarts at digit 0 in DEAD.
- Simultaneous events: blink toggle on the same cycle as the DEAD->SHOW edge uses the pre-toggle blink_phase.

Decomposition:
- Shared package constants: SEG_OFF=7'h7F, AN_OFF=4'hF, NUM_DIGITS=4, FSM state encoding (DEAD=0, SHOW=1).
- One natural sub-module: the team's existing 4-bit hex-to-segment decoder, instantiated once on the snapshot nibble.
- Everything else (FSM, counters, blank logic) lives in this module.

Test Plan (REFRESH_DIV=4, DEAD_CYC=1, BLINK_DIV=40):
- Reset then digits=16'h1250, all controls 0 -> after reset: DEAD 1 cycle, slot_tick pulses. Next cycles an=1110, seg=7'b1000000 for 4 cycles, then 1 cycle an=1111. Then an=1101 seg=7'b0010010, an=1011 seg=7'b0100100, an=0111 seg=7'b1111001; wraps back to an=1110. Scan period 20 cycles. an never has two zero bits.
- lzb_en=1, digits=16'h0050 -> digits 3 and 2 dark (an stays 1111 in their slots); digit 1 shows 5; digit 0 shows 0. With digits=16'h0000, only digit 0 lights, seg=7'b1000000.
- blink_en=4'b0001, dp_in=4'b0010 -> digit 0 lit for 40 cycles and dark for 40 in alternation. Digit 1 shows dp=0 when lit; other digits dp=1.
- Change digits from 16'h1111 to 16'h2222 on the 2nd cycle of digit 1's SHOW -> digit 1 keeps seg=7'b1111001 to slot end. Digit 2's slot shows seg=7'b0100100.
- Assert rst during digit 2's SHOW -> next cycle an=1111, seg=7F, dp=1, slot_tick=0. After release, first lit digit is digit 0, after 1 DEAD cycle.
- blank_mask=4'b1111 for a full scan -> an stays 1111 throughout; slot_tick still pulses every 5 cycles.
